pa_fpu_frbus: RTL and testbench

PA_FPU_FRBUS -- requirements
Module: pa_fpu_frbus

---
 rtl/pa_fpu_frbus.sv | 177 +++++++++++++++++
 tb/tb_pa_fpu_frbus.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_fpu_frbus.sv
// pa_fpu_frbus: floating-point result bus arbiter.
// Merges the fixed-latency pipe results (FALU/FMAU) and the held divide/sqrt
// (FDSU) results onto one registered FP register-file write port. The pipe
// normally has priority. A starvation counter forces the FDSU ahead of the
// pipe after STARVE_LIMIT consecutive denied cycles.
// Optional feature: define PA_FPU_FRBUS_FFLAGS_ACC_EN to add a sticky
// exception-flag accumulator (frbus_fflags_acc, cleared by cp0_fpu_fflags_clr).
module pa_fpu_frbus #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic              rtu_yy_xx_flush,
    input  logic              pipe_frbus_vld,
    input  logic [DATA_W-1:0] pipe_frbus_data,
    input  logic [4:0]        pipe_frbus_fflags,
    input  logic [4:0]        pipe_frbus_freg,
    input  logic              fdsu_frbus_wb_vld,
    input  logic [DATA_W-1:0] fdsu_frbus_data,
    input  logic [4:0]        fdsu_frbus_fflags,
    input  logic [4:0]        fdsu_frbus_freg,
`ifdef PA_FPU_FRBUS_FFLAGS_ACC_EN
    input  logic              cp0_fpu_fflags_clr,
    output logic [4:0]        frbus_fflags_acc,
`endif
    output logic              frbus_fdsu_wb_grant,
    output logic              frbus_pipe_stall,
    output logic              frbus_rf_wen,
    output logic [4:0]        frbus_rf_waddr,
    output logic [DATA_W-1:0] frbus_rf_wdata,
    output logic              frbus_fflags_vld,
    output logic [4:0]        frbus_fflags
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_e;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              fdsu_grant;
    logic              pipe_stall;

    logic              wen_q, wen_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        fflags_q, fflags_d;

    // Arbitration: a pipe result can never be held, so it always wins; the
    // FORCE state only stalls the pipe upstream. Both outputs are held low in reset.
    always_comb begin
        fdsu_grant = 1'b0;
        pipe_stall = 1'b0;
        if (!cpurst) begin
            pipe_stall = (state_q == ST_FORCE);
            fdsu_grant = fdsu_frbus_wb_vld & ~pipe_frbus_vld;
        end
    end

    // Next state: count consecutive FDSU denials in NORMAL, leave FORCE once
    // the FDSU is served or withdraws; a flush always returns to a clean NORMAL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (fdsu_frbus_wb_vld && !fdsu_grant) begin
                    if (cnt_q + 3'd1 == LIMIT) begin
                        state_d = ST_FORCE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = 3'd0;
                end
            end
            ST_FORCE: begin
                cnt_d = 3'd0;
                if (fdsu_grant || !fdsu_frbus_wb_vld) begin
                    state_d = ST_NORMAL;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                cnt_d   = 3'd0;
            end
        endcase
        if (rtu_yy_xx_flush) begin
            state_d = ST_NORMAL;
            cnt_d   = 3'd0;
        end
    end

    // Arbitration state register.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q <= ST_NORMAL;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write-back select: pipe first, else the granted FDSU; payload holds when idle.
    always_comb begin
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        fflags_d = fflags_q;
        if (pipe_frbus_vld) begin
            wen_d    = 1'b1;
            waddr_d  = pipe_frbus_freg;
            wdata_d  = pipe_frbus_data;
            fflags_d = pipe_frbus_fflags;
        end else if (fdsu_grant) begin
            wen_d    = 1'b1;
            waddr_d  = fdsu_frbus_freg;
            wdata_d  = fdsu_frbus_data;
            fflags_d = fdsu_frbus_fflags;
        end
    end

    // Registered register-file write and flag report; unaffected by flush.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            wen_q    <= 1'b0;
            waddr_q  <= 5'd0;
            wdata_q  <= '0;
            fflags_q <= 5'd0;
        end else begin
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            fflags_q <= fflags_d;
        end
    end

    assign frbus_fdsu_wb_grant = fdsu_grant;
    assign frbus_pipe_stall    = pipe_stall;
    assign frbus_rf_wen        = wen_q;
    assign frbus_rf_waddr      = waddr_q;
    assign frbus_rf_wdata      = wdata_q;
    assign frbus_fflags_vld    = wen_q;
    assign frbus_fflags        = fflags_q;

`ifdef PA_FPU_FRBUS_FFLAGS_ACC_EN
    logic [4:0] acc_q, acc_d;

    // Sticky flags: OR in every reported flag set; a clear wins over a same-cycle OR.
    always_comb begin
        acc_d = acc_q;
        if (cp0_fpu_fflags_clr) begin
            acc_d = 5'd0;
        end else if (wen_q) begin
            acc_d = acc_q | fflags_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            acc_q <= 5'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign frbus_fflags_acc = acc_q;
`endif

endmodule

// File: tb/tb_pa_fpu_frbus.sv
// tb_pa_fpu_frbus: directed self-checking bench for pa_fpu_frbus (STARVE_LIMIT = 4).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 2 units after the edge, registered outputs 1 unit after the edge.
module tb_pa_fpu_frbus;

   logic        clock;
   logic        reset;
   logic        flush;
   logic        pipeVld;
   logic [31:0] pipeData;
   logic [4:0]  pipeFflags;
   logic [4:0]  pipeFreg;
   logic        fdsuVld;
   logic [31:0] fdsuData;
   logic [4:0]  fdsuFflags;
   logic [4:0]  fdsuFreg;
   logic        grant;
   logic        stall;
   logic        rfWen;
   logic [4:0]  rfWaddr;
   logic [31:0] rfWdata;
   logic        fflagsVld;
   logic [4:0]  fflags;
`ifdef PA_FPU_FRBUS_FFLAGS_ACC_EN
   logic        fflagsClr;
   logic [4:0]  fflagsAcc;
`endif

   int vecCount  = 0;
   int missCount = 0;

   pa_fpu_frbus #(.DATA_W(32), .STARVE_LIMIT(4)) dut (
      .forever_cpuclk     (clock),
      .cpurst             (reset),
      .rtu_yy_xx_flush    (flush),
      .pipe_frbus_vld     (pipeVld),
      .pipe_frbus_data    (pipeData),
      .pipe_frbus_fflags  (pipeFflags),
      .pipe_frbus_freg    (pipeFreg),
      .fdsu_frbus_wb_vld  (fdsuVld),
      .fdsu_frbus_data    (fdsuData),
      .fdsu_frbus_fflags  (fdsuFflags),
      .fdsu_frbus_freg    (fdsuFreg),
`ifdef PA_FPU_FRBUS_FFLAGS_ACC_EN
      .cp0_fpu_fflags_clr (fflagsClr),
      .frbus_fflags_acc   (fflagsAcc),
`endif
      .frbus_fdsu_wb_grant(grant),
      .frbus_pipe_stall   (stall),
      .frbus_rf_wen       (rfWen),
      .frbus_rf_waddr     (rfWaddr),
      .frbus_rf_wdata     (rfWdata),
      .frbus_fflags_vld   (fflagsVld),
      .frbus_fflags       (fflags)
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                                input logic [4:0] pf, input logic fv, input logic [4:0] fr,
                                input logic [31:0] fd, input logic [4:0] ff);
      pipeVld    = pv;
      pipeFreg   = pr;
      pipeData   = pd;
      pipeFflags = pf;
      fdsuVld    = fv;
      fdsuFreg   = fr;
      fdsuData   = fd;
      fdsuFflags = ff;
   endtask

   task automatic applyIdle;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
   endtask

   // Reset values appear without a clock, even with both requesters active.
   task automatic test_reset;
      reset = 1'b1;
      flush = 1'b0;
      applyStimulus(1'b1, 5'd3, 32'hDEAD_BEEF, 5'd1, 1'b1, 5'd4, 32'h1234_5678, 5'd2);
      #3;
      vecCount++; if (rfWen !== 1'b0) begin missCount++; $display("[TB] FAIL reset_wen: got %b want 0", rfWen); end
      vecCount++; if (rfWaddr !== 5'd0) begin missCount++; $display("[TB] FAIL reset_waddr: got %0d want 0", rfWaddr); end
      vecCount++; if (rfWdata !== 32'h0) begin missCount++; $display("[TB] FAIL reset_wdata: got %h want 0", rfWdata); end
      vecCount++; if (fflagsVld !== 1'b0) begin missCount++; $display("[TB] FAIL reset_fflags_vld: got %b want 0", fflagsVld); end
      vecCount++; if (fflags !== 5'd0) begin missCount++; $display("[TB] FAIL reset_fflags: got %b want 0", fflags); end
      vecCount++; if (grant !== 1'b0) begin missCount++; $display("[TB] FAIL reset_grant: got %b want 0", grant); end
      vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
`ifdef PA_FPU_FRBUS_FFLAGS_ACC_EN
      vecCount++; if (fflagsAcc !== 5'd0) begin missCount++; $display("[TB] FAIL reset_acc: got %b want 0", fflagsAcc); end
`endif
      tick;
      applyIdle();
      reset = 1'b0;
      tick;
      vecCount++; if (rfWen !== 1'b0) begin missCount++; $display("[TB] FAIL idle_wen: got %b want 0", rfWen); end
   endtask

   // FDSU alone is granted in the same cycle and written one cycle later.
   task automatic test_fdsu_alone;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 5'd5, 32'h3F80_0000, 5'b00001);
      #1;
      vecCount++; if (grant !== 1'b1) begin missCount++; $display("[TB] FAIL alone_grant: got %b want 1", grant); end
      vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL alone_stall: got %b want 0", stall); end
      tick;
      applyIdle();
      vecCount++; if (rfWen !== 1'b1) begin missCount++; $display("[TB] FAIL alone_wen: got %b want 1", rfWen); end
      vecCount++; if (rfWaddr !== 5'd5) begin missCount++; $display("[TB] FAIL alone_waddr: got %0d want 5", rfWaddr); end
      vecCount++; if (rfWdata !== 32'h3F80_0000) begin missCount++; $display("[TB] FAIL alone_wdata: got %h want 3f800000", rfWdata); end
      vecCount++; if (fflagsVld !== 1'b1) begin missCount++; $display("[TB] FAIL alone_fflags_vld: got %b want 1", fflagsVld); end
      vecCount++; if (fflags !== 5'b00001) begin missCount++; $display("[TB] FAIL alone_fflags: got %b want 00001", fflags); end
      tick;
      vecCount++; if (rfWen !== 1'b0) begin missCount++; $display("[TB] FAIL alone_wen_drop: got %b want 0", rfWen); end
      vecCount++; if (fflagsVld !== 1'b0) begin missCount++; $display("[TB] FAIL alone_fvld_drop: got %b want 0", fflagsVld); end
      vecCount++; if (rfWaddr !== 5'd5) begin missCount++; $display("[TB] FAIL alone_waddr_hold: got %0d want 5", rfWaddr); end
      vecCount++; if (rfWdata !== 32'h3F80_0000) begin missCount++; $display("[TB] FAIL alone_wdata_hold: got %h want 3f800000", rfWdata); end
   endtask

   // Four denials force the FDSU ahead; it is granted on cycle 5, NORMAL on cycle 6.
   task automatic test_contention;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 32'(32'h100 + i), 5'd0, 1'b1, 5'd7, 32'h4000_0000, 5'd0);
         #1;
         vecCount++; if (grant !== 1'b0) begin missCount++; $display("[TB] FAIL cont_grant c%0d: got %b want 0", i, grant); end
         vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL cont_stall c%0d: got %b want 0", i, stall); end
         tick;
         vecCount++; if (rfWaddr !== 5'(i + 1)) begin missCount++; $display("[TB] FAIL cont_pipe_waddr c%0d: got %0d want %0d", i, rfWaddr, i + 1); end
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 5'd7, 32'h4000_0000, 5'd0);
      #1;
      vecCount++; if (stall !== 1'b1) begin missCount++; $display("[TB] FAIL cont_force_stall: got %b want 1", stall); end
      vecCount++; if (grant !== 1'b1) begin missCount++; $display("[TB] FAIL cont_force_grant: got %b want 1", grant); end
      tick;
      applyIdle();
      vecCount++; if (rfWaddr !== 5'd7) begin missCount++; $display("[TB] FAIL cont_fdsu_waddr: got %0d want 7", rfWaddr); end
      vecCount++; if (rfWdata !== 32'h4000_0000) begin missCount++; $display("[TB] FAIL cont_fdsu_wdata: got %h want 40000000", rfWdata); end
      #1;
      vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL cont_normal_stall: got %b want 0", stall); end
      tick;
      vecCount++; if (rfWen !== 1'b0) begin missCount++; $display("[TB] FAIL cont_no_dup: got %b want 0", rfWen); end
   endtask

   // Same-cycle pipe and FDSU: pipe written first, FDSU next, one grant only.
   task automatic test_simultaneous;
      applyStimulus(1'b1, 5'd2, 32'hAAAA_0002, 5'b00010, 1'b1, 5'd9, 32'h9999_0009, 5'b01000);
      #1;
      vecCount++; if (grant !== 1'b0) begin missCount++; $display("[TB] FAIL sim_grant0: got %b want 0", grant); end
      tick;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 5'd9, 32'h9999_0009, 5'b01000);
      vecCount++; if (rfWaddr !== 5'd2) begin missCount++; $display("[TB] FAIL sim_waddr_pipe: got %0d want 2", rfWaddr); end
      vecCount++; if (fflags !== 5'b00010) begin missCount++; $display("[TB] FAIL sim_fflags_pipe: got %b want 00010", fflags); end
      #1;
      vecCount++; if (grant !== 1'b1) begin missCount++; $display("[TB] FAIL sim_grant1: got %b want 1", grant); end
      tick;
      applyIdle();
      vecCount++; if (rfWen !== 1'b1) begin missCount++; $display("[TB] FAIL sim_wen_fdsu: got %b want 1", rfWen); end
      vecCount++; if (rfWaddr !== 5'd9) begin missCount++; $display("[TB] FAIL sim_waddr_fdsu: got %0d want 9", rfWaddr); end
      vecCount++; if (fflags !== 5'b01000) begin missCount++; $display("[TB] FAIL sim_fflags_fdsu: got %b want 01000", fflags); end
      tick;
      vecCount++; if (rfWen !== 1'b0) begin missCount++; $display("[TB] FAIL sim_single: got %b want 0", rfWen); end
   endtask

   // A pipe result arriving in FORCE still wins, and FORCE is kept for the FDSU.
   task automatic test_protocol_error;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 32'h0, 5'd0, 1'b1, 5'd13, 32'hD, 5'd0);
         tick;
      end
      applyStimulus(1'b1, 5'd12, 32'hC, 5'd0, 1'b1, 5'd13, 32'hD, 5'd0);
      #1;
      vecCount++; if (stall !== 1'b1) begin missCount++; $display("[TB] FAIL perr_stall: got %b want 1", stall); end
      vecCount++; if (grant !== 1'b0) begin missCount++; $display("[TB] FAIL perr_grant: got %b want 0", grant); end
      tick;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 5'd13, 32'hD, 5'd0);
      vecCount++; if (rfWaddr !== 5'd12) begin missCount++; $display("[TB] FAIL perr_pipe_waddr: got %0d want 12", rfWaddr); end
      #1;
      vecCount++; if (stall !== 1'b1) begin missCount++; $display("[TB] FAIL perr_still_force: got %b want 1", stall); end
      vecCount++; if (grant !== 1'b1) begin missCount++; $display("[TB] FAIL perr_grant2: got %b want 1", grant); end
      tick;
      applyIdle();
      vecCount++; if (rfWaddr !== 5'd13) begin missCount++; $display("[TB] FAIL perr_fdsu_waddr: got %0d want 13", rfWaddr); end
      tick;
   endtask

   // Flush leaves FORCE without a spurious write and clears the denial count.
   task automatic test_flush;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 32'h0, 5'd0, 1'b1, 5'd20, 32'h20, 5'd0);
         tick;
      end
      applyStimulus(1'b1, 5'd21, 32'h21, 5'd0, 1'b1, 5'd20, 32'h20, 5'd0);
      flush = 1'b1;
      #1;
      vecCount++; if (stall !== 1'b1) begin missCount++; $display("[TB] FAIL flush_cur_stall: got %b want 1", stall); end
      vecCount++; if (grant !== 1'b0) begin missCount++; $display("[TB] FAIL flush_cur_grant: got %b want 0", grant); end
      tick;
      flush = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 5'd20, 32'h20, 5'd0);
      vecCount++; if (rfWaddr !== 5'd21) begin missCount++; $display("[TB] FAIL flush_pipe_waddr: got %0d want 21", rfWaddr); end
      #1;
      vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL flush_next_stall: got %b want 0", stall); end
      vecCount++; if (grant !== 1'b1) begin missCount++; $display("[TB] FAIL flush_next_grant: got %b want 1", grant); end
      tick;
      applyIdle();
      vecCount++; if (rfWaddr !== 5'd20) begin missCount++; $display("[TB] FAIL flush_fdsu_waddr: got %0d want 20", rfWaddr); end
      tick;
      vecCount++; if (rfWen !== 1'b0) begin missCount++; $display("[TB] FAIL flush_spurious_wen: got %b want 0", rfWen); end
      // Three denials, then a fourth together with a flush: count restarts at zero.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 32'h0, 5'd0, 1'b1, 5'd22, 32'h22, 5'd0);
         flush = (i == 3);
         tick;
      end
      flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 32'h0, 5'd0, 1'b1, 5'd22, 32'h22, 5'd0);
         #1;
         vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL flush_cnt_clear c%0d: got %b want 0", i, stall); end
         tick;
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 5'd22, 32'h22, 5'd0);
      #1;
      vecCount++; if (stall !== 1'b1) begin missCount++; $display("[TB] FAIL flush_reforce: got %b want 1", stall); end
      tick;
      applyIdle();
      tick;
   endtask

   // Asynchronous reset at cnt = 3 zeroes outputs; a fresh 4 denials are needed.
   task automatic test_reset_mid;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 32'(32'h55 + i), 5'b00100, 1'b1, 5'd30, 32'h30, 5'd0);
         tick;
      end
      applyStimulus(1'b1, 5'd4, 32'h58, 5'b00100, 1'b1, 5'd30, 32'h30, 5'd0);
      #2;
      reset = 1'b1;
      #1;
      vecCount++; if (rfWen !== 1'b0) begin missCount++; $display("[TB] FAIL rmid_wen: got %b want 0", rfWen); end
      vecCount++; if (rfWaddr !== 5'd0) begin missCount++; $display("[TB] FAIL rmid_waddr: got %0d want 0", rfWaddr); end
      vecCount++; if (rfWdata !== 32'h0) begin missCount++; $display("[TB] FAIL rmid_wdata: got %h want 0", rfWdata); end
      vecCount++; if (fflags !== 5'd0) begin missCount++; $display("[TB] FAIL rmid_fflags: got %b want 0", fflags); end
      vecCount++; if (grant !== 1'b0) begin missCount++; $display("[TB] FAIL rmid_grant: got %b want 0", grant); end
      tick;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 32'h0, 5'd0, 1'b1, 5'd30, 32'h30, 5'd0);
         #1;
         vecCount++; if (stall !== 1'b0) begin missCount++; $display("[TB] FAIL rmid_fresh c%0d: got %b want 0", i, stall); end
         tick;
         vecCount++; if (rfWen !== 1'b1) begin missCount++; $display("[TB] FAIL rmid_capture c%0d: got %b want 1", i, rfWen); end
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 5'd30, 32'h30, 5'd0);
      #1;
      vecCount++; if (stall !== 1'b1) begin missCount++; $display("[TB] FAIL rmid_force: got %b want 1", stall); end
      tick;
      applyIdle();
      vecCount++; if (rfWaddr !== 5'd30) begin missCount++; $display("[TB] FAIL rmid_fdsu_waddr: got %0d want 30", rfWaddr); end
      tick;
   endtask

`ifdef PA_FPU_FRBUS_FFLAGS_ACC_EN
   // Sticky flags accumulate across writes; clear beats a same-cycle OR.
   task automatic test_fflags_acc;
      fflagsClr = 1'b1;
      tick;
      fflagsClr = 1'b0;
      applyStimulus(1'b1, 5'd1, 32'h1, 5'b00001, 1'b0, 5'd0, 32'h0, 5'd0);
      tick;
      applyStimulus(1'b1, 5'd2, 32'h2, 5'b10000, 1'b0, 5'd0, 32'h0, 5'd0);
      tick;
      applyIdle();
      tick;
      vecCount++; if (fflagsAcc !== 5'b10001) begin missCount++; $display("[TB] FAIL acc_or: got %b want 10001", fflagsAcc); end
      applyStimulus(1'b1, 5'd3, 32'h3, 5'b00100, 1'b0, 5'd0, 32'h0, 5'd0);
      tick;
      applyIdle();
      fflagsClr = 1'b1;
      tick;
      fflagsClr = 1'b0;
      vecCount++; if (fflagsAcc !== 5'b00000) begin missCount++; $display("[TB] FAIL acc_clr_wins: got %b want 00000", fflagsAcc); end
   endtask
`endif

   // Test sequence.
   initial begin
`ifdef PA_FPU_FRBUS_FFLAGS_ACC_EN
      fflagsClr = 1'b0;
`endif
      test_reset();
      test_fdsu_alone();
      test_contention();
      test_simultaneous();
      test_protocol_error();
      test_flush();
      test_reset_mid();
`ifdef PA_FPU_FRBUS_FFLAGS_ACC_EN
      test_fflags_acc();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
